// File: rtl/v68k_bus_controller.sv
// 68000-style asynchronous bus cycle engine for the V68k core.
// One byte/word/long request at a time; a long access runs as two word cycles.
module v68k_bus_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [23:0] req_addr_i,
  input  logic        req_rw_i,
  input  logic [1:0]  req_size_i,
  input  logic [2:0]  req_fc_i,
  input  logic [31:0] req_wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        addr_err_o,
  output logic        busy_o,
  output logic [22:0] a_o,
  output logic        uds_o,
  output logic        lds_o,
  output logic        as_o,
  output logic        rw_o,
  output logic [2:0]  fc_o,
  inout  wire  [15:0] d_io,
  input  logic        dtack_i,
  input  logic        berr_i
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STROBE, S_WAIT, S_END} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  fc_q, fc_d;
  logic [31:0] wdata_q, wdata_d;
  logic        second_q, second_d;
  logic [15:0] hi_q, hi_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        err_q, err_d;
  logic        aerr_q, aerr_d;

  logic        in_strobe;
  logic        cont_long;
  logic        misaligned;
  logic [15:0] wlane;

  assign in_strobe  = (state_q == S_STROBE) || (state_q == S_WAIT);
  // A clean first half of a long loops back for the second word instead of acking.
  assign cont_long  = (size_q == 2'd2) && !second_q && !err_q && !aerr_q;
  assign misaligned = (req_size_i == 2'd3) || ((req_size_i != 2'd0) && req_addr_i[0]);

  always_comb begin
    wlane = wdata_q[15:0];
    case (size_q)
      2'd0:    wlane = {wdata_q[7:0], wdata_q[7:0]};
      2'd2:    wlane = second_q ? wdata_q[15:0] : wdata_q[31:16];
      default: wlane = wdata_q[15:0];
    endcase
  end

  assign d_io       = (in_strobe && !rw_q) ? wlane : 16'hzzzz;
  assign as_o       = in_strobe;
  assign uds_o      = in_strobe && ((size_q != 2'd0) || !addr_q[0]);
  assign lds_o      = in_strobe && ((size_q != 2'd0) || addr_q[0]);
  assign a_o        = addr_q[23:1];
  assign rw_o       = rw_q;
  assign fc_o       = fc_q;
  assign busy_o     = (state_q != S_IDLE);
  assign ack_o      = (state_q == S_END) && !cont_long;
  assign err_o      = ack_o && err_q;
  assign addr_err_o = ack_o && aerr_q;
  assign rdata_o    = rdata_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    size_d   = size_q;
    fc_d     = fc_q;
    wdata_d  = wdata_q;
    second_d = second_q;
    hi_d     = hi_q;
    rdata_d  = rdata_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    aerr_d   = aerr_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          err_d = 1'b0;
          if (misaligned) begin
            // Pins keep their previous values: no bus cycle is started.
            aerr_d  = 1'b1;
            state_d = S_END;
          end else begin
            aerr_d   = 1'b0;
            addr_d   = req_addr_i;
            rw_d     = req_rw_i;
            size_d   = req_size_i;
            fc_d     = req_fc_i;
            wdata_d  = req_wdata_i;
            second_d = 1'b0;
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        tcnt_d  = 8'd0;
        state_d = S_STROBE;
      end
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        if (berr_i) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else if (dtack_i) begin
          state_d = S_END;
          if (rw_q) begin
            if (size_q == 2'd0)
              rdata_d = {24'h0, addr_q[0] ? d_io[7:0] : d_io[15:8]};
            else if (size_q == 2'd1)
              rdata_d = {16'h0, d_io};
            else if (!second_q)
              hi_d = d_io;
            else
              rdata_d = {hi_q, d_io};
          end
        end else if (tcnt_q >= TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else begin
          tcnt_d = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
        end
      end
      S_END: begin
        if (cont_long) begin
          addr_d   = addr_q + 24'd2;
          second_d = 1'b1;
          state_d  = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      addr_q   <= 24'h0;
      rw_q     <= 1'b1;
      size_q   <= 2'd0;
      fc_q     <= 3'd0;
      wdata_q  <= 32'h0;
      second_q <= 1'b0;
      hi_q     <= 16'h0;
      rdata_q  <= 32'h0;
      tcnt_q   <= 8'd0;
      err_q    <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      fc_q     <= fc_d;
      wdata_q  <= wdata_d;
      second_q <= second_d;
      hi_q     <= hi_d;
      rdata_q  <= rdata_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      aerr_q   <= aerr_d;
    end
  end

endmodule

// File: doc/v68k_bus_controller.md
# v68k_bus_controller

Executes 68000-style asynchronous bus cycles on behalf of the V68k core. It sits directly downstream of the core's execution state machine: it accepts one byte, word or long memory request at a time and drives the external address and data-strobe pins. It waits on DTACK, returns read data and reports bus or address errors. Long accesses are split into two sequential word cycles.

## Interface
- TIMEOUT, default 255: WAIT-state cycles without DTACK/BERR before a cycle is aborted as a bus error; legal range 1..255.
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- req  in  1  request valid (level); sampled only in IDLE
- req_addr  in  24  byte address
- req_rw  in  1  1 = read, 0 = write
- req_size  in  2  0 = byte, 1 = word, 2 = long, 3 = illegal
- req_fc  in  3  function code for the access
- req_wdata  in  32  write data, right-justified
- ack  out  1  one-cycle completion pulse
- rdata  out  32  read data, valid while ack = 1
- err  out  1  with ack: cycle ended by BERR or timeout
- addr_err  out  1  with ack: misaligned or illegal request; no bus cycle run
- busy  out  1  state != IDLE
- A  out  23  address bits [23:1]
- UDS / LDS  out  1 each  upper (D[15:8]) / lower (D[7:0]) data strobe
- AS  out  1  address strobe
- RW  out  1  bus direction; 1 = read
- FC  out  3  function code
- D  inout  16  data bus; driven only during write STROBE/WAIT
- DTACK  in  1  data transfer acknowledge
- BERR  in  1  bus error

All pin signals are active-high at this level.

## Operation
- States: IDLE, ADDR, STROBE, WAIT, END.
- IDLE, req = 1:
  - Latch the request.
  - Odd address with word/long, or size 3: go to END with addr_err = 1 and no pin activity.
  - Otherwise go to ADDR.
- ADDR: A, FC and RW are valid; AS, UDS and LDS are 0.
- STROBE: AS = 1; strobes asserted; for writes, D is driven. Lasts exactly one cycle, then WAIT.
- WAIT: AS, strobes and D are held. DTACK and BERR are sampled on each edge.
  - BERR = 1 (wins over DTACK): go to END with err = 1.
  - DTACK = 1: capture D, go to END.
  - Timeout counter reaches TIMEOUT: treated as BERR.
- END: AS and strobes are 0; D is released.
  - If the first half of a long completed without error: address += 2, go to ADDR.
  - Otherwise ack = 1 for this cycle, then IDLE.
- Strobes:
  - Byte: addr[0] = 0 selects UDS; addr[0] = 1 selects LDS.
  - Word/long: both strobes.
- Write data:
  - Byte: req_wdata[7:0] replicated on D[15:8] and D[7:0].
  - Word: req_wdata[15:0].
  - Long: req_wdata[31:16] in the first cycle, then [15:0].
- Read data:
  - Byte: selected lane in rdata[7:0], upper bits 0.
  - Word: rdata[15:0], upper bits 0.
  - Long: first word in rdata[31:16], second in [15:0].
- A long aborted by an error in its first half does not run the second half.
- The timeout counter is 8 bits, cleared on entry to STROBE, and saturates; it never wraps.

## Timing
- Reset values: AS = UDS = LDS = 0, RW = 1, A = 0, FC = 0, D released, ack = err = addr_err = busy = 0, rdata = 0, state IDLE. Reset mid-cycle aborts on the next edge with no ack.
- Take the accepting edge as t0. With DTACK already high, ack is high in cycle t0+4 for byte/word and t0+8 for long. Each WAIT cycle without DTACK adds 1 cycle.
- addr_err: ack is high in cycle t0+1.
- The requester holds req and the req_* inputs stable until ack, and drops req on the edge that samples ack. One IDLE cycle always separates two requests.
- rdata holds its value until the next ack.

## Test plan
- Word read at 0x001000, DTACK high from STROBE, D = 0xBEEF -> A = 0x000800, UDS = LDS = 1, ack at t0+4, rdata = 0x0000BEEF, err = 0.
- Byte write 0x5A to 0x000003 -> LDS = 1, UDS = 0, RW = 0, D = 0x5A5A during STROBE/WAIT, ack at t0+4.
- Long read at 0x000100, DTACK delayed 2 cycles on the second word, D = 0x1234 then 0x5678 -> A = 0x80 then 0x81, ack at t0+10, rdata = 0x12345678.
- Long write, BERR = 1 together with DTACK in the first WAIT -> ack with err = 1 at t0+4; no second ADDR state.
- Word read with TIMEOUT = 4, DTACK never asserted -> ack with err = 1 after 4 WAIT cycles; word read at odd address 0x000011 -> ack with addr_err = 1 at t0+1, AS stays 0.
- RESET = 1 during WAIT -> next cycle AS = UDS = LDS = 0, D released, busy = 0, no ack.
